// File: rtl/inst_encoder.sv
// MIPS32 instruction encoder: turns symbolic requests into machine words,
// tags each word with a sequential byte address and streams them from a FIFO.
module inst_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_base,
    input  logic [31:0]                base_addr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [5:0]                 in_op,
    input  logic [4:0]                 in_rs,
    input  logic [4:0]                 in_rt,
    input  logic [4:0]                 in_rd,
    input  logic [31:0]                in_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_word,
    output logic [31:0]                out_addr,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       err_illegal,
    output logic [CNT_W-1:0]           illegal_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12, F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A;
    localparam logic [5:0] F_DIVU = 6'h1B, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26;
    localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;
    localparam logic [5:0] OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LB = 6'h20, OP_LH = 6'h21;
    localparam logic [5:0] OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB = 6'h28;
    localparam logic [5:0] OP_SH = 6'h29, OP_SW = 6'h2B;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [31:0] enc_w0, enc_w1;
    logic        enc_legal, enc_two;

    always_comb begin
        enc_w0    = '0;
        enc_w1    = '0;
        enc_legal = 1'b1;
        enc_two   = 1'b0;
        case (in_op)
            6'd0:  enc_w0 = r_word(5'd0, in_rt, in_rd, in_imm[4:0], F_SLL);
            6'd1:  enc_w0 = r_word(5'd0, in_rt, in_rd, in_imm[4:0], F_SRL);
            6'd2:  enc_w0 = r_word(5'd0, in_rt, in_rd, in_imm[4:0], F_SRA);
            6'd3:  enc_w0 = r_word(in_rs, in_rt, in_rd, 5'd0, F_SLLV);
            6'd4:  enc_w0 = r_word(in_rs, in_rt, in_rd, 5'd0, F_SRLV);
            6'd5:  enc_w0 = r_word(in_rs, in_rt, in_rd, 5'd0, F_SRAV);
            6'd6:  enc_w0 = r_word(in_rs, 5'd0, 5'd0, 5'd0, F_JR);
            6'd7:  enc_w0 = r_word(5'd0, 5'd0, in_rd, 5'd0, F_MFHI);
            6'd8:  enc_w0 = r_word(5'd0, 5'd0, in_rd, 5'd0, F_MFLO);
            6'd9:  enc_w0 = r_word(in_rs, in_rt, 5'd0, 5'd0, F_MULT);
            6'd10: enc_w0 = r_word(in_rs, in_rt, 5'd0, 5'd0, F_MULTU);
            6'd11: enc_w0 = r_word(in_rs, in_rt, 5'd0, 5'd0, F_DIV);
            6'd12: enc_w0 = r_word(in_rs, in_rt, 5'd0, 5'd0, F_DIVU);
            6'd13: enc_w0 = r_word(in_rs, in_rt, in_rd, 5'd0, F_ADD);
            6'd14: enc_w0 = r_word(in_rs, in_rt, in_rd, 5'd0, F_ADDU);
            6'd15: enc_w0 = r_word(in_rs, in_rt, in_rd, 5'd0, F_SUB);
            6'd16: enc_w0 = r_word(in_rs, in_rt, in_rd, 5'd0, F_SUBU);
            6'd17: enc_w0 = r_word(in_rs, in_rt, in_rd, 5'd0, F_AND);
            6'd18: enc_w0 = r_word(in_rs, in_rt, in_rd, 5'd0, F_OR);
            6'd19: enc_w0 = r_word(in_rs, in_rt, in_rd, 5'd0, F_XOR);
            6'd20: enc_w0 = r_word(in_rs, in_rt, in_rd, 5'd0, F_NOR);
            6'd21: enc_w0 = r_word(in_rs, in_rt, in_rd, 5'd0, F_SLT);
            6'd22: enc_w0 = r_word(in_rs, in_rt, in_rd, 5'd0, F_SLTU);
            6'd23: enc_w0 = {OP_JAL, in_imm[25:0]};
            6'd24: enc_w0 = i_word(OP_BEQ, in_rs, in_rt, in_imm[15:0]);
            6'd25: enc_w0 = i_word(OP_BNE, in_rs, in_rt, in_imm[15:0]);
            6'd26: enc_w0 = i_word(OP_ADDI, in_rs, in_rt, in_imm[15:0]);
            6'd27: enc_w0 = i_word(OP_ADDIU, in_rs, in_rt, in_imm[15:0]);
            6'd28: enc_w0 = i_word(OP_SLTI, in_rs, in_rt, in_imm[15:0]);
            6'd29: enc_w0 = i_word(OP_ANDI, in_rs, in_rt, in_imm[15:0]);
            6'd30: enc_w0 = i_word(OP_ORI, in_rs, in_rt, in_imm[15:0]);
            6'd31: enc_w0 = i_word(OP_XORI, in_rs, in_rt, in_imm[15:0]);
            6'd32: enc_w0 = i_word(OP_LUI, 5'd0, in_rt, in_imm[15:0]);
            6'd33: enc_w0 = i_word(OP_LB, in_rs, in_rt, in_imm[15:0]);
            6'd34: enc_w0 = i_word(OP_LH, in_rs, in_rt, in_imm[15:0]);
            6'd35: enc_w0 = i_word(OP_LW, in_rs, in_rt, in_imm[15:0]);
            6'd36: enc_w0 = i_word(OP_LBU, in_rs, in_rt, in_imm[15:0]);
            6'd37: enc_w0 = i_word(OP_LHU, in_rs, in_rt, in_imm[15:0]);
            6'd38: enc_w0 = i_word(OP_SB, in_rs, in_rt, in_imm[15:0]);
            6'd39: enc_w0 = i_word(OP_SH, in_rs, in_rt, in_imm[15:0]);
            6'd40: enc_w0 = i_word(OP_SW, in_rs, in_rt, in_imm[15:0]);
            6'd41: begin
                // LI: LUI of the upper half, then ORI of the lower half into the same rt
                enc_w0  = i_word(OP_LUI, 5'd0, in_rt, in_imm[31:16]);
                enc_w1  = i_word(OP_ORI, in_rt, in_rt, in_imm[15:0]);
                enc_two = 1'b1;
            end
            default: enc_legal = 1'b0;
        endcase
    end

    logic [31:0]      word_q [DEPTH];
    logic [31:0]      word_d [DEPTH];
    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      addr_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic             accept, pop;
    logic [1:0]       push_n;
    logic [31:0]      first_addr;

    // Room for two words is required so an LI can always be accepted whole.
    assign in_ready  = ~rst & (level_q <= LW'(DEPTH - 2));
    assign out_valid = (level_q != '0);
    assign out_word  = out_valid ? word_q[rd_ptr_q] : '0;
    assign out_addr  = out_valid ? addr_q[rd_ptr_q] : '0;
    assign level       = level_q;
    assign err_illegal = err_q;
    assign illegal_cnt = ill_cnt_q;

    always_comb begin
        accept     = in_valid & in_ready;
        pop        = out_valid & out_ready;
        push_n     = (accept & enc_legal) ? (enc_two ? 2'd2 : 2'd1) : 2'd0;
        first_addr = load_base ? base_addr : cnt_q;
        word_d     = word_q;
        addr_d     = addr_q;
        if (push_n != 2'd0) begin
            word_d[wr_ptr_q] = enc_w0;
            addr_d[wr_ptr_q] = first_addr;
        end
        if (push_n == 2'd2) begin
            word_d[wr_ptr_q + AW'(1)] = enc_w1;
            addr_d[wr_ptr_q + AW'(1)] = first_addr + 32'd4;
        end
        wr_ptr_d  = wr_ptr_q + AW'(push_n);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        level_d   = level_q + LW'(push_n) - LW'(pop);
        cnt_d     = first_addr + (32'(push_n) << 2);
        err_d     = err_q;
        ill_cnt_d = ill_cnt_q;
        if (accept & ~enc_legal) begin
            err_d = 1'b1;
            if (ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                addr_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ill_cnt_q <= '0;
        end else begin
            word_q    <= word_d;
            addr_q    <= addr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: table of encodings plus hand sequences for LI,
// back-pressure, illegal-op saturation and mid-stream reset.
module tb_inst_encoder;
    logic        clk = 1'b0;
    logic        rst, load_base, in_valid, in_ready, out_valid, out_ready, err_illegal;
    logic [31:0] base_addr, in_imm, out_word, out_addr;
    logic [5:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [2:0]  level;
    logic [7:0]  illegal_cnt;

    inst_encoder #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .load_base(load_base), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
        .level(level), .err_illegal(err_illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_addr = 32'd0;
    logic [63:0] mon_e;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm;
        logic [31:0] w0, w1;
    } vec_t;
    vec_t vecs[20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every word leaving the FIFO is compared against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_word: got %h@%h expected none", out_word, out_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_word", {32'd0, out_word}, {32'd0, mon_e[63:32]});
                check("out_addr", {32'd0, out_addr}, {32'd0, mon_e[31:0]});
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] imm, input logic lb,
                        input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1);
        int t = 0;
        in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
        load_base = lb; base_addr = base;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
            in_valid = 1'b0; load_base = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; load_base = 1'b0;
        if (lb) exp_addr = base;
        if (op <= 6'd41) begin
            exp_q.push_back({w0, exp_addr});
            exp_addr = exp_addr + 32'd4;
            if (op == 6'd41) begin
                exp_q.push_back({w1, exp_addr});
                exp_addr = exp_addr + 32'd4;
            end
        end
    endtask

    task automatic wait_empty();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_queue", 64'(exp_q.size()), 64'd0);
        check("drain_level", {61'd0, level}, 64'd0);
    endtask

    function automatic logic [31:0] addu_word(input logic [4:0] rs, input logic [4:0] rt,
                                              input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, 6'h21};
    endfunction

    initial begin
        vecs[0]  = '{6'd14, 5'd2,  5'd3,  5'd1,  32'h0,        32'h00430821, 32'h0};
        vecs[1]  = '{6'd0,  5'd7,  5'd2,  5'd1,  32'd10,       32'h00020A80, 32'h0};
        vecs[2]  = '{6'd23, 5'd4,  5'd5,  5'd6,  32'h40,       32'h0C000040, 32'h0};
        vecs[3]  = '{6'd40, 5'd29, 5'd5,  5'd9,  32'hFFFC,     32'hAFA5FFFC, 32'h0};
        vecs[4]  = '{6'd2,  5'd9,  5'd5,  5'd4,  32'd31,       32'h000527C3, 32'h0};
        vecs[5]  = '{6'd3,  5'd6,  5'd7,  5'd8,  32'h1F,       32'h00C74004, 32'h0};
        vecs[6]  = '{6'd6,  5'd31, 5'd3,  5'd4,  32'h0,        32'h03E00008, 32'h0};
        vecs[7]  = '{6'd7,  5'd5,  5'd6,  5'd2,  32'h0,        32'h00001010, 32'h0};
        vecs[8]  = '{6'd9,  5'd4,  5'd5,  5'd7,  32'h0,        32'h00850018, 32'h0};
        vecs[9]  = '{6'd16, 5'd1,  5'd2,  5'd3,  32'hFFFFFFFF, 32'h00221823, 32'h0};
        vecs[10] = '{6'd20, 5'd31, 5'd31, 5'd31, 32'h0,        32'h03FFF827, 32'h0};
        vecs[11] = '{6'd24, 5'd1,  5'd2,  5'd9,  32'hFFFFFFFE, 32'h1022FFFE, 32'h0};
        vecs[12] = '{6'd27, 5'd29, 5'd29, 5'd0,  32'h0000FFF8, 32'h27BDFFF8, 32'h0};
        vecs[13] = '{6'd32, 5'd5,  5'd1,  5'd3,  32'hABCD,     32'h3C01ABCD, 32'h0};
        vecs[14] = '{6'd35, 5'd4,  5'd2,  5'd1,  32'h8,        32'h8C820008, 32'h0};
        vecs[15] = '{6'd22, 5'd3,  5'd4,  5'd5,  32'h0,        32'h0064282B, 32'h0};
        vecs[16] = '{6'd41, 5'd7,  5'd31, 5'd2,  32'hDEADBEEF, 32'h3C1FDEAD, 32'h37FFBEEF};
        vecs[17] = '{6'd31, 5'd2,  5'd3,  5'd1,  32'h12340F0F, 32'h38430F0F, 32'h0};
        vecs[18] = '{6'd12, 5'd8,  5'd9,  5'd10, 32'h0,        32'h0109001B, 32'h0};
        vecs[19] = '{6'd38, 5'd16, 5'd17, 5'd3,  32'h10,       32'hA2110010, 32'h0};

        rst = 1'b1; load_base = 1'b0; base_addr = '0; in_valid = 1'b0; in_op = '0;
        in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", {61'd0, level}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_err", {63'd0, err_illegal}, 64'd0);
        check("rst_cnt", {56'd0, illegal_cnt}, 64'd0);
        check("rst_out_word", {32'd0, out_word}, 64'd0);
        check("rst_out_addr", {32'd0, out_addr}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First word: one-cycle latency from accept to out_valid.
        check("pre_out_valid", {63'd0, out_valid}, 64'd0);
        send(6'd14, 5'd2, 5'd3, 5'd1, 32'h0, 1'b0, 32'h0, 32'h00430821, 32'h0);
        check("lat_out_valid", {63'd0, out_valid}, 64'd1);
        check("lat_out_word", {32'd0, out_word}, 64'h00430821);
        check("lat_out_addr", {32'd0, out_addr}, 64'h0);
        out_ready = 1'b1;
        wait_empty();

        for (int i = 0; i < 20; i++)
            send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, 1'b0, 32'h0,
                 vecs[i].w0, vecs[i].w1);
        for (int i = 0; i < 8; i++) begin
            logic [4:0] rs, rt, rd;
            rs = 5'($urandom_range(31, 0));
            rt = 5'($urandom_range(31, 0));
            rd = 5'($urandom_range(31, 0));
            send(6'd14, rs, rt, rd, $urandom, 1'b0, 32'h0, addu_word(rs, rt, rd), 32'h0);
        end
        wait_empty();

        // LI with load_base in the same cycle.
        out_ready = 1'b0;
        send(6'd41, 5'd0, 5'd8, 5'd0, 32'h12345678, 1'b1, 32'h100, 32'h3C081234, 32'h35085678);
        check("li_level", {61'd0, level}, 64'd2);
        check("li_head_word", {32'd0, out_word}, 64'h3C081234);
        check("li_head_addr", {32'd0, out_addr}, 64'h100);
        send(6'd14, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h0, 32'h00221821, 32'h0);
        check("li_next_addr", {32'd0, exp_addr}, 64'h10C);
        out_ready = 1'b1;
        wait_empty();

        // Back-pressure until full, then release.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(6'd14, 5'(i), 5'(i + 1), 5'(i + 2), 32'h0, 1'b0, 32'h0,
                 addu_word(5'(i), 5'(i + 1), 5'(i + 2)), 32'h0);
        check("full_level", {61'd0, level}, 64'd3);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        #1;
        check("pop_same_cycle_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("pop_next_in_ready", {63'd0, in_ready}, 64'd1);
        check("pop_next_level", {61'd0, level}, 64'd2);
        wait_empty();

        // Illegal ops: consumed, counted, counter untouched.
        send(6'd63, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        check("ill_err", {63'd0, err_illegal}, 64'd1);
        check("ill_cnt1", {56'd0, illegal_cnt}, 64'd1);
        check("ill_level", {61'd0, level}, 64'd0);
        for (int i = 0; i < 254; i++)
            send(6'($urandom_range(63, 42)), 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        check("ill_cnt255", {56'd0, illegal_cnt}, 64'd255);
        send(6'd42, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        check("ill_cnt_sat", {56'd0, illegal_cnt}, 64'd255);
        send(6'd14, 5'd4, 5'd5, 5'd6, 32'h0, 1'b0, 32'h0, addu_word(5'd4, 5'd5, 5'd6), 32'h0);
        wait_empty();

        // Reset mid-stream discards buffered words and restarts addressing.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(6'd14, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0, 32'h0, addu_word(5'd1, 5'd1, 5'd1), 32'h0);
        check("mid_level", {61'd0, level}, 64'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_level", {61'd0, level}, 64'd0);
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_err", {63'd0, err_illegal}, 64'd0);
        check("mid_rst_cnt", {56'd0, illegal_cnt}, 64'd0);
        exp_q.delete();
        exp_addr = 32'd0;
        out_ready = 1'b0;
        send(6'd14, 5'd2, 5'd3, 5'd1, 32'h0, 1'b0, 32'h0, 32'h00430821, 32'h0);
        check("post_rst_addr", {32'd0, out_addr}, 64'h0);
        out_ready = 1'b1;
        wait_empty();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Turns symbolic instruction requests (op index, register numbers, immediate) into 32-bit MIPS32 machine words. This is the encoder counterpart of the instruction decoder. It is used by the self-test/program-loader path to fill instruction memory. Words are buffered in a small FIFO, tagged with a sequential byte address, and streamed out over a valid/ready interface. The pseudo-op LI expands into LUI+ORI.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >=2
CNT_W, 8, width of illegal-op counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
load_base  in  1  pulse: load address counter from base_addr
base_addr  in  32  start byte address
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&in_ready
in_op  in  6  op index (see Behaviour)
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field
in_imm  in  32  immediate / shamt / jump target / LI constant
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_word  out  32  encoded instruction at head
out_addr  out  32  byte address of head word
level  out  $clog2(DEPTH)+1  FIFO occupancy
err_illegal  out  1  sticky: illegal op seen
illegal_cnt  out  CNT_W  illegal-op count, saturating

Behaviour:
- Op indices:
  - 0 SLL, 1 SRL, 2 SRA, 3 SLLV, 4 SRLV, 5 SRAV, 6 JR, 7 MFHI, 8 MFLO.
  - 9 MULT, 10 MULTU, 11 DIV, 12 DIVU.
  - 13 ADD, 14 ADDU, 15 SUB, 16 SUBU, 17 AND, 18 OR, 19 XOR, 20 NOR, 21 SLT, 22 SLTU.
  - 23 JAL, 24 BEQ, 25 BNE.
  - 26 ADDI, 27 ADDIU, 28 SLTI, 29 ANDI, 30 ORI, 31 XORI, 32 LUI.
  - 33 LB, 34 LH, 35 LW, 36 LBU, 37 LHU, 38 SB, 39 SH, 40 SW.
  - 41 LI.
  - 42..63 illegal.
- Opcode/funct values are the standard MIPS32 values from the project defines file.
- Field rules:
  - R-type: {0, rs, rt, rd, shamt, funct}.
  - SLL/SRL/SRA: rs=0, shamt=in_imm[4:0]. All other R-type ops: shamt=0.
  - JR: rt=rd=0. MFHI/MFLO: rs=rt=0. MULT/DIV family: rd=0.
  - I-type: {op, rs, rt, in_imm[15:0]}. LUI: rs=0.
  - JAL: {op, in_imm[25:0]}.
  - Unused input fields are ignored, never OR'd into the word.
- LI: first word is LUI rt,in_imm[31:16]; second word is ORI rt,rt,in_imm[15:0]. Both are pushed in the same accepting cycle, LUI first.
- in_ready = (DEPTH - level >= 2) & ~rst. The register only reflects pops after the edge, so a same-cycle pop does not raise in_ready.
- Encode is combinational. The FIFO write happens at the accepting edge. out_valid rises the cycle after acceptance (1-cycle latency).
- out_valid = level!=0. out_word/out_addr are stable while out_valid & ~out_ready.
- Simultaneous push and pop are legal. Level update = +pushed(0/1/2) - popped(0/1).
- Address counter:
  - Each pushed word takes the current counter value; the counter then advances by 4 per word (LI advances by 8). Wraps modulo 2^32.
  - load_base has priority: when asserted in the same cycle as an accept, base_addr is used for the first pushed word.
- Illegal op (42..63) with in_valid & in_ready:
  - The request is consumed; nothing is pushed and the counter does not advance.
  - err_illegal <= 1; illegal_cnt increments, saturating at all-ones.
- Reset values: level=0, out_valid=0, FIFO pointers 0, counter 0, err_illegal=0, illegal_cnt=0, out_word/out_addr=0. Reset mid-stream discards all buffered words.

Test Plan:
- base 0x0; ADDU rs=2 rt=3 rd=1 -> out_word 0x00430821, out_addr 0x0, out_valid one cycle after accept.
- SLL rd=1 rt=2 in_imm=10, with in_rs=7 (must be ignored) -> 0x00020A80. JAL in_imm=0x40 -> 0x0C000040. SW rs=29 rt=5 imm=0xFFFC -> 0xAFA5FFFC.
- load_base=0x100 with LI rt=8 imm=0x12345678 in the same cycle -> 0x3C081234@0x100, then 0x35085678@0x104; level peaks at 2; the next word goes to 0x108.
- DEPTH=4, out_ready=0: accept 3 ADDU -> level=3, in_ready=0. Then out_ready=1 -> in_ready=1 the following cycle; words drain in order with consecutive addresses.
- in_op=63 -> err_illegal=1, illegal_cnt=1, level unchanged, counter unchanged. Repeat 256 times at CNT_W=8 -> saturates at 255.
- level=3 pending, assert rst for one cycle -> level=0, out_valid=0, err_illegal=0. The next word is emitted at address 0x0.
